// File: rtl/cp0_exc_ctrl_if.sv
// M-stage to CP0 exception controller bundle: pipeline-side controls in,
// redirect request and CP0 read data out.
interface cp0_exc_ctrl_if;
    logic [5:0]  ExcCodeM;
    logic [31:0] PCM;
    logic        BDM;
    logic        EretM;
    logic        CP0WeM;
    logic [4:0]  CP0AddrM;
    logic [31:0] CP0WDM;
    logic [5:0]  HWInt;
    logic [31:0] CP0RD;
    logic [31:0] EPCOut;
    logic        Req;
    logic [31:0] NPC;

    modport master (
        output ExcCodeM, PCM, BDM, EretM, CP0WeM, CP0AddrM, CP0WDM, HWInt,
        input  CP0RD, EPCOut, Req, NPC
    );

    modport slave (
        input  ExcCodeM, PCM, BDM, EretM, CP0WeM, CP0AddrM, CP0WDM, HWInt,
        output CP0RD, EPCOut, Req, NPC
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId, redirect decision for
// interrupts, exceptions and eret, plus a one-cycle bubble after each redirect.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID       = 32'h2024_1127
) (
    input  logic             clk,
    input  logic             reset,
    cp0_exc_ctrl_if.slave    bus
);
    typedef enum logic {IDLE, BUBBLE} state_t;

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    state_t      state, state_next;
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        take_trap;
    logic        do_eret;
    logic        do_mtc0;
    logic [31:0] sr;
    logic [31:0] cause;

    assign sr      = {16'b0, im, 8'b0, exl, ie};
    assign cause   = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
    assign int_req = (|(bus.HWInt & im)) & ie & ~exl;
    assign exc_req = bus.ExcCodeM[5] & ~exl;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        bus.Req    = 1'b0;
        bus.NPC    = HANDLER_PC;
        take_trap  = 1'b0;
        do_eret    = 1'b0;
        do_mtc0    = 1'b0;
        case (state)
            IDLE: begin
                if (int_req || exc_req) begin
                    bus.Req    = 1'b1;
                    take_trap  = 1'b1;
                    state_next = BUBBLE;
                end else if (bus.EretM) begin
                    bus.Req    = 1'b1;
                    bus.NPC    = epc;
                    do_eret    = 1'b1;
                    state_next = BUBBLE;
                end else if (bus.CP0WeM) begin
                    do_mtc0    = 1'b1;
                end
            end
            // The M slot holds the flushed instruction, so nothing acts here.
            BUBBLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!reset) begin
            bus.Req = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            state <= state_next;
            ip    <= bus.HWInt;
            if (take_trap) begin
                exl      <= 1'b1;
                epc      <= bus.BDM ? bus.PCM - 32'd4 : bus.PCM;
                bd       <= bus.BDM;
                exc_code <= int_req ? 5'd0 : bus.ExcCodeM[4:0];
            end else if (do_eret) begin
                exl <= 1'b0;
            end else if (do_mtc0) begin
                if (bus.CP0AddrM == ADDR_SR) begin
                    im  <= bus.CP0WDM[15:10];
                    exl <= bus.CP0WDM[1];
                    ie  <= bus.CP0WDM[0];
                end else if (bus.CP0AddrM == ADDR_EPC) begin
                    epc <= bus.CP0WDM;
                end
            end
        end
    end

    always_comb begin
        case (bus.CP0AddrM)
            ADDR_SR:    bus.CP0RD = sr;
            ADDR_CAUSE: bus.CP0RD = cause;
            ADDR_EPC:   bus.CP0RD = epc;
            ADDR_PRID:  bus.CP0RD = PRID;
            default:    bus.CP0RD = 32'h0;
        endcase
    end

    assign bus.EPCOut = epc;
endmodule
